// File: rtl/vga_sram_pixel_reader.sv
// Raster-order framebuffer fetch over AXI-Lite reads (one read outstanding),
// buffered through a first-word-fall-through FIFO into a ready/valid pixel stream.
module vga_sram_pixel_reader #(
    parameter int AXI_ADDR_WIDTH = 20,
    parameter int AXI_DATA_WIDTH = 16,
    parameter int H_VISIBLE      = 640,
    parameter int V_VISIBLE      = 480,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    output logic [AXI_ADDR_WIDTH-1:0] axi_araddr,
    output logic                      axi_arvalid,
    input  logic                      axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0] axi_rdata,
    input  logic [1:0]                axi_rresp,
    input  logic                      axi_rvalid,
    output logic                      axi_rready,
    output logic [AXI_DATA_WIDTH-1:0] pixel_data,
    output logic                      pixel_sof,
    output logic                      pixel_eol,
    output logic                      pixel_valid,
    input  logic                      pixel_ready,
    output logic                      read_error
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = AXI_DATA_WIDTH + 2;
    localparam logic [31:0]      H_VIS_W   = 32'(H_VISIBLE);
    localparam logic [9:0]       COL_LAST  = 10'(H_VISIBLE - 1);
    localparam logic [9:0]       ROW_LAST  = 10'(V_VISIBLE - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ALMOST = CNT_W'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t                    state_r, state_s;
    logic [9:0]                col_r, row_r, col_s, row_s;
    logic [AXI_ADDR_WIDTH-1:0] araddr_r, addr_next_s;
    logic                      arvalid_r, rready_r, read_error_r;

    logic [ENTRY_W-1:0]        mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]          count_r;
    logic                      push_s, pop_s, fifo_valid_s;
    logic                      sof_s, eol_s;
    logic [ENTRY_W-1:0]        head_s;

    assign push_s       = rready_r && axi_rvalid;
    assign fifo_valid_s = (count_r != {CNT_W{1'b0}});
    assign pop_s        = fifo_valid_s && pixel_ready;
    assign sof_s        = (row_r == 10'd0) && (col_r == 10'd0);
    assign eol_s        = (col_r == COL_LAST);
    assign head_s       = mem_r[rd_ptr_r];

    // Next-state, next fetch position and the address to present on entering ADDR
    always_comb begin
        state_s = state_r;
        col_s   = col_r;
        row_s   = row_r;
        case (state_r)
            ST_IDLE: begin
                if (enable && (count_r < CNT_FULL)) begin
                    state_s = ST_ADDR;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (axi_arready) begin
                    state_s = ST_DATA;
                end else begin
                    state_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (axi_rvalid) begin
                    if (col_r < COL_LAST) begin
                        col_s = col_r + 10'd1;
                    end else begin
                        col_s = 10'd0;
                        if (row_r < ROW_LAST) begin
                            row_s = row_r + 10'd1;
                        end else begin
                            row_s = 10'd0;
                        end
                    end
                    // Pre-cycle count: a pop in this same cycle earns no credit
                    if (enable && (count_r < CNT_ALMOST)) begin
                        state_s = ST_ADDR;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        addr_next_s = AXI_ADDR_WIDTH'(32'(row_s) * H_VIS_W + 32'(col_s));
    end

    // FSM state, registered AXI outputs, fetch position and sticky error flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            arvalid_r    <= 1'b0;
            rready_r     <= 1'b0;
            araddr_r     <= {AXI_ADDR_WIDTH{1'b0}};
            col_r        <= 10'd0;
            row_r        <= 10'd0;
            read_error_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            arvalid_r <= (state_s == ST_ADDR);
            rready_r  <= (state_s == ST_DATA);
            col_r     <= col_s;
            row_r     <= row_s;
            if ((state_s == ST_ADDR) && (state_r != ST_ADDR)) begin
                araddr_r <= addr_next_s;
            end
            if (push_s && (axi_rresp != 2'b00)) begin
                read_error_r <= 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; left unreset so it can map onto distributed RAM
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {sof_s, eol_s, axi_rdata};
        end
    end

    assign axi_araddr  = araddr_r;
    assign axi_arvalid = arvalid_r;
    assign axi_rready  = rready_r;
    assign read_error  = read_error_r;
    assign pixel_valid = fifo_valid_s;
    // Head fields are masked while empty so reset and drained states read as zero
    assign pixel_data  = fifo_valid_s ? head_s[AXI_DATA_WIDTH-1:0] : {AXI_DATA_WIDTH{1'b0}};
    assign pixel_eol   = fifo_valid_s && head_s[AXI_DATA_WIDTH];
    assign pixel_sof   = fifo_valid_s && head_s[AXI_DATA_WIDTH+1];

endmodule
